// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Multiplexed NUM_DIGITS x hex-to-7-segment driver. A packed value plus
//   per-digit decimal points is captured into a shadow register by LOAD and
//   copied to the display register only at a frame boundary, so a frame is
//   never drawn from two different values. Each digit slot lasts SCAN_DIV
//   cycles; the first BLANK_CYCLES of every slot keep all digits off to
//   suppress ghosting while the segment bus settles.
//
//   Optional build macro HEXDISP_LZB_EN: leading-zero blanking. Digits above
//   the most significant nonzero nibble show all segments off (digit 0 is
//   never blanked). The DP of a blanked digit is still driven.
//
// Ports
//   CLOCK_50  in   system clock
//   RESET     in   asynchronous active-high reset
//   LOAD      in   one-cycle strobe capturing VALUE / DP_IN into the shadow
//   VALUE     in   packed nibbles, VALUE[3:0] is digit 0 (rightmost)
//   DP_IN     in   decimal point per digit
//   ENABLE    in   0 turns every digit off; scanning keeps running
//   SEG       out  segments {g,f,e,d,c,b,a}, registered
//   DP        out  decimal point of the current digit, registered
//   DIG_SEL   out  one-hot digit enable, registered
//   UPDATED   out  one-cycle pulse after a pending load reaches the display
module hex_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    ENABLE,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   DIG_SEL,
  output logic                    UPDATED
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // XOR masks applied at the output flops; also the reset ("inactive") levels.
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic                    frame_end;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    lz_blank;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   dig_raw;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);

  // Scan position: cnt counts cycles inside a slot, idx selects the digit.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      if (idx == IDX_LAST) idx <= '0;
      else                 idx <= idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow/display handoff. A LOAD on the boundary cycle lands in the shadow
  // after the old shadow has been copied out, so it stays pending one frame.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      UPDATED    <= 1'b0;
    end else begin
      UPDATED <= frame_end && pending;
      if (frame_end && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (LOAD) begin
        shadow_val <= VALUE;
        shadow_dp  <= DP_IN;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    dig_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = disp_val[4*i +: 4];
        cur_dp  = disp_dp[i];
      end
      dig_raw[i] = ENABLE && (cnt >= CNT_BLANK) && (idx == IDX_W'(i));
    end
  end

`ifdef HEXDISP_LZB_EN
  logic [IDX_W-1:0] msd;

  // msd stays 0 for an all-zero value, which keeps digit 0 showing "0".
  always_comb begin
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_val[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
    lz_blank = (idx > msd);
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign seg_raw = lz_blank ? 7'h00 : seg_decode(cur_nib);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      SEG     <= SEG_INV;
      DP      <= DP_INV;
      DIG_SEL <= DIG_INV;
    end else begin
      SEG     <= seg_raw ^ SEG_INV;
      DP      <= cur_dp ^ DP_INV;
      DIG_SEL <= dig_raw ^ DIG_INV;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic        LOAD     = 1'b0;
  logic        ENABLE   = 1'b1;
  logic [15:0] VALUE    = '0;
  logic [3:0]  DP_IN    = '0;

  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;
  logic [3:0] dig_h, dig_l;
  logic       upd_h, upd_l;

  always #10 CLOCK_50 = ~CLOCK_50;

  hex_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut_h (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .LOAD(LOAD), .VALUE(VALUE),
    .DP_IN(DP_IN), .ENABLE(ENABLE), .SEG(seg_h), .DP(dp_h),
    .DIG_SEL(dig_h), .UPDATED(upd_h)
  );

  hex_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut_l (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .LOAD(LOAD), .VALUE(VALUE),
    .DP_IN(DP_IN), .ENABLE(ENABLE), .SEG(seg_l), .DP(dp_l),
    .DIG_SEL(dig_l), .UPDATED(upd_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed cycles since reset plus the value registers.
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_disp_dp, m_shadow_dp;
  bit          m_pending;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] expected_seg(input logic [15:0] v, input int slot);
    logic [3:0] nib;
`ifdef HEXDISP_LZB_EN
    int msd;
    msd = 0;
    for (int i = 0; i < ND; i++) if (((v >> (4*i)) & 16'hF) != 16'h0) msd = i;
    if (slot > msd) return 7'h00;
`endif
    nib = 4'((v >> (4*slot)) & 16'hF);
    return SEG_TAB[nib];
  endfunction

  task automatic reset_model();
    m_t = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pending = 0;
  endtask

  // One clock: drive inputs, predict the outputs produced at this edge, then
  // advance the model and compare both polarity variants.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit en);
    int slot, phase;
    bit bnd;
    logic [6:0] e_seg;
    logic e_dp, e_upd;
    logic [3:0] e_dig;
    LOAD = ld; VALUE = v; DP_IN = d; ENABLE = en;
    phase = m_t % SD;
    slot  = (m_t / SD) % ND;
    bnd   = (m_t % FRAME) == FRAME - 1;
    e_seg = expected_seg(m_disp, slot);
    e_dp  = m_disp_dp[slot];
    e_dig = (en && phase >= BC) ? 4'(1 << slot) : 4'h0;
    e_upd = bnd && m_pending;
    @(posedge CLOCK_50);
    if (bnd && m_pending) begin
      m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pending = 0;
    end
    if (ld) begin
      m_shadow = v; m_shadow_dp = d; m_pending = 1;
    end
    m_t++;
    #1;
    check("outputs_high", 32'({seg_h, dp_h, dig_h, upd_h}), 32'({e_seg, e_dp, e_dig, e_upd}));
    check("outputs_low",  32'({seg_l, dp_l, dig_l, upd_l}), 32'({~e_seg, ~e_dp, ~e_dig, e_upd}));
    LOAD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 16'h0, 4'h0, 1);
  endtask

  task automatic align(input int target);
    while ((m_t % FRAME) != target) step(0, 16'h0, 4'h0, 1);
  endtask

  task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dps);
    segs = '1;
    dps  = 'x;
    for (int k = 0; k < FRAME; k++) begin
      step(0, 16'h0, 4'h0, 1);
      for (int i = 0; i < ND; i++) begin
        if (dig_h == 4'(1 << i)) begin
          segs[7*i +: 7] = seg_h;
          dps[i] = dp_h;
        end
      end
    end
  endtask

  task automatic wait_updated();
    bit seen;
    seen = 0;
    for (int k = 0; k < 2*FRAME + 2 && !seen; k++) begin
      step(0, 16'h0, 4'h0, 1);
      seen = upd_h;
    end
    check("updated_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [27:0] segs;
    logic [3:0]  dps;
    int cnt;

    vecs[0] = '{16'h1A2F, 4'b0100, {7'h06, 7'h77, 7'h5B, 7'h71}};
    vecs[1] = '{16'h5678, 4'b0000, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
`ifdef HEXDISP_LZB_EN
    vecs[2] = '{16'h0030, 4'b0001, {7'h00, 7'h00, 7'h4F, 7'h3F}};
    vecs[3] = '{16'h0000, 4'b1000, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[4] = '{16'h0E0D, 4'b0011, {7'h00, 7'h79, 7'h3F, 7'h5E}};
`else
    vecs[2] = '{16'h0030, 4'b0001, {7'h3F, 7'h3F, 7'h4F, 7'h3F}};
    vecs[3] = '{16'h0000, 4'b1000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[4] = '{16'h0E0D, 4'b0011, {7'h3F, 7'h79, 7'h3F, 7'h5E}};
`endif

    // Reset state, both polarities.
    #25;
    check("reset_seg_h", 32'(seg_h), 32'h00);
    check("reset_dig_h", 32'(dig_h), 32'h0);
    check("reset_dp_h",  32'(dp_h),  32'h0);
    check("reset_upd_h", 32'(upd_h), 32'h0);
    check("reset_seg_l", 32'(seg_l), 32'h7F);
    check("reset_dig_l", 32'(dig_l), 32'hF);
    check("reset_dp_l",  32'(dp_l),  32'h1);
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    reset_model();

    // Idle after reset: 3F everywhere, 24 of 32 cycles with a digit on.
    cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      step(0, 16'h0, 4'h0, 1);
      if (dig_h != 4'h0) cnt++;
    end
    check("active_cycles_per_frame", 32'(cnt), 32'd24);

    // Table: load mid-frame, wait for the handoff, then read one frame back.
    foreach (vecs[r]) begin
      align(13);
      step(1, vecs[r].v, vecs[r].dp, 1);
      wait_updated();
      capture_frame(segs, dps);
      check($sformatf("vec%0d_segs", r), 32'(segs), 32'(vecs[r].segs));
      check($sformatf("vec%0d_dps", r),  32'(dps),  32'(vecs[r].dp));
    end

    // Two loads in one frame: one UPDATED, last value wins.
    align(5);
    step(1, 16'h1234, 4'h0, 1);
    idle(5);
    step(1, 16'h5678, 4'h0, 1);
    cnt = 0;
    for (int k = 0; k < 2*FRAME; k++) begin
      step(0, 16'h0, 4'h0, 1);
      if (upd_h) cnt++;
    end
    check("double_load_pulses", 32'(cnt), 32'd1);
    capture_frame(segs, dps);
    check("double_load_segs", 32'(segs), 32'({7'h6D, 7'h7D, 7'h07, 7'h7F}));

    // LOAD exactly on the boundary while 0001 is pending.
    align(3);
    step(1, 16'h0001, 4'h0, 1);
    align(FRAME - 1);
    step(1, 16'hFFFF, 4'h0, 1);
    cnt = upd_h ? 1 : 0;
    capture_frame(segs, dps);
`ifdef HEXDISP_LZB_EN
    check("boundary_first_segs", 32'(segs), 32'({7'h00, 7'h00, 7'h00, 7'h06}));
`else
    check("boundary_first_segs", 32'(segs), 32'({7'h3F, 7'h3F, 7'h3F, 7'h06}));
`endif
    if (upd_h) cnt++;
    for (int k = 0; k < 2*FRAME; k++) begin
      step(0, 16'h0, 4'h0, 1);
      if (upd_h) cnt++;
    end
    check("boundary_pulses", 32'(cnt), 32'd2);
    capture_frame(segs, dps);
    check("boundary_second_segs", 32'(segs), 32'({7'h71, 7'h71, 7'h71, 7'h71}));

    // ENABLE low for 40 cycles; model checks digits off and scan phase kept.
    align(6);
    for (int k = 0; k < 40; k++) begin
      step(0, 16'h0, 4'h0, 0);
      if (dig_l != 4'hF) check("enable_off_dig_l", 32'(dig_l), 32'hF);
    end
    idle(FRAME);

    // Reset mid-slot with a load pending: outputs go inactive at once and the
    // pending value is dropped.
    align(12);
    step(1, 16'hABCD, 4'hF, 1);
    idle(2);
    RESET = 1'b1;
    #1;
    check("async_reset_dig_l", 32'(dig_l), 32'hF);
    check("async_reset_seg_l", 32'(seg_l), 32'h7F);
    check("async_reset_dig_h", 32'(dig_h), 32'h0);
    check("async_reset_seg_h", 32'(seg_h), 32'h00);
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    reset_model();
    cnt = 0;
    for (int k = 0; k < 2*FRAME; k++) begin
      step(0, 16'h0, 4'h0, 1);
      if (upd_h) cnt++;
    end
    check("pending_dropped_by_reset", 32'(cnt), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom),
           $urandom_range(0, 7) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Parametrised multi-digit hex-to-7-segment driver for the board display.
- Latches a packed NUM_DIGITS x 4-bit value plus per-digit decimal points.
- Time-multiplexes digits onto one shared segment bus with a one-hot digit select, a prescaled scan rate and anti-ghosting blanking.
- New values are applied only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal 1..8.
- SCAN_DIV, 50000: CLOCK_50 cycles per digit slot; legal >=2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off; legal 0..SCAN_DIV-1.
- SEG_ACTIVE_LOW, 0: 1 inverts SEG and DP at the output.
- DIG_ACTIVE_LOW, 0: 1 inverts DIG_SEL at the output.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  asynchronous active-high reset.
- LOAD  in  1  one-cycle strobe; captures VALUE and DP_IN.
- VALUE  in  4*NUM_DIGITS  packed nibbles; VALUE[3:0] is digit 0 (rightmost).
- DP_IN  in  NUM_DIGITS  decimal point per digit.
- ENABLE  in  1  0 forces all digits inactive; scanning continues.
- SEG  out  7  segments {g,f,e,d,c,b,a}, bit0=a; registered.
- DP  out  1  decimal point; registered.
- DIG_SEL  out  NUM_DIGITS  one-hot digit enable; registered.
- UPDATED  out  1  one-cycle pulse when a pending load is applied.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - prescaler cnt=0, digit index idx=0;
  - display register, shadow register and pending flag = 0;
  - UPDATED=0; SEG, DP and DIG_SEL all inactive after polarity is applied.
- Reset mid-frame aborts the slot. Any pending load is discarded.
- Scan counter: cnt runs 0..SCAN_DIV-1. When cnt wraps from SCAN_DIV-1 to 0, idx increments; NUM_DIGITS-1 wraps to 0.
- Frame boundary: the cycle with idx=NUM_DIGITS-1 and cnt=SCAN_DIV-1.
- Load:
  - LOAD=1 writes VALUE/DP_IN into the shadow register and sets pending.
  - A second LOAD before the boundary overwrites the shadow. Only the last value is shown.
  - On a frame boundary with pending=1: display <= shadow, pending cleared, UPDATED=1 on the next cycle.
  - LOAD in the same cycle as the boundary: the previous shadow is applied, the new value is written to the shadow, and pending stays 1.
- Output stage: registered, one cycle after state (idx, cnt).
  - DIG_SEL[idx] is active iff ENABLE=1 and cnt>=BLANK_CYCLES; all other digits are inactive.
  - SEG = decode(display nibble idx); DP = display DP bit idx.
- Decode table (active-high, hex):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Blank pattern: SEG=00 active-high, i.e. all segments off.
- Polarity: SEG_ACTIVE_LOW and DIG_ACTIVE_LOW invert the final registered outputs only. The "inactive" levels in the reset values follow these parameters.
- NUM_DIGITS=1: idx stays 0; a frame boundary occurs every SCAN_DIV cycles.

Optional Feature:
- Macro: HEXDISP_LZB_EN (leading-zero blanking).
- Defined:
  - Any digit above the most significant nonzero nibble of the display register outputs the blank pattern.
  - Digit 0 is never blanked; all-zero shows a single "0".
  - DP of a blanked digit is still driven from its DP bit.
- Undefined: every digit is always decoded, with no blanking logic synthesised.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, polarities 0 unless stated):
- Reset release, no LOAD -> every slot shows SEG=3F; DIG_SEL cycles 0001,0010,0100,1000; each digit active 6 of 8 cycles and off 2; frame=32 cycles.
- LOAD VALUE=16'h1A2F, DP_IN=4'b0100 mid-frame -> display unchanged until the boundary; UPDATED pulses once; the next frame shows digit0=71, digit1=5B, digit2=77 with DP=1, digit3=06.
- LOAD 16'h1234 then LOAD 16'h5678 in the same frame -> one UPDATED pulse; the next frame shows 6D,7D,07,7F as digits 3..0.
- LOAD asserted exactly on the boundary cycle with 16'hFFFF while 16'h0001 is pending -> 0001 is shown next frame; FFFF is shown the frame after; two UPDATED pulses.
- ENABLE=0 for 40 cycles, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 -> DIG_SEL=1111 throughout while idx keeps advancing; after ENABLE=1 the scan resumes in phase; RESET mid-slot -> DIG_SEL=1111 and SEG=7F immediately (asynchronous).
- With HEXDISP_LZB_EN, VALUE=16'h0030 -> digits 3..2 blank (SEG=00), digit1=4F, digit0=3F; VALUE=0 -> only digit0 shows 3F.
